// File: rtl/rle_stream_encoder.sv
// Streaming run-length encoder: one coefficient per cycle in, (value, count, last) pairs out.
// Generic RLE or zero-run mode; a non-merging final element costs one FLUSH cycle.
module rle_stream_encoder #(
    parameter int DATA_WIDTH = 8,
    parameter int BLOCK_LEN  = 64,
    parameter int CNT_WIDTH  = 7,
    parameter int MAX_RUN    = 64
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    input  logic                  mode_in,
    output logic [DATA_WIDTH-1:0] run_value_out,
    output logic [CNT_WIDTH-1:0]  run_count_out,
    output logic                  run_last_out,
    output logic                  run_valid_out,
    input  logic                  run_ready_in,
    output logic [CNT_WIDTH-1:0]  runs_out,
    output logic                  block_done_out
);
    localparam int IDX_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    typedef enum logic {ACCUM, FLUSH} state_t;

    state_t                state_q, state_d;
    logic                  open_q, open_d;
    logic [DATA_WIDTH-1:0] val_q, val_d;
    logic [CNT_WIDTH-1:0]  len_q, len_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  mode_q, mode_d;
    logic                  ovld_q, ovld_d;
    logic [DATA_WIDTH-1:0] oval_q, oval_d;
    logic [CNT_WIDTH-1:0]  ocnt_q, ocnt_d;
    logic                  olast_q, olast_d;
    logic [CNT_WIDTH-1:0]  runs_q, runs_d;
    logic                  done_q, done_d;

    logic                  out_free, accept, is_last, merge;
    logic                  ld, ld_last;
    logic [DATA_WIDTH-1:0] ld_val;
    logic [CNT_WIDTH-1:0]  ld_cnt;

    assign out_free  = !ovld_q || run_ready_in;
    assign ready_out = (state_q == ACCUM) && out_free && rst_n_in;
    assign accept    = valid_in && ready_out;
    assign is_last   = (idx_q == IDX_W'(BLOCK_LEN - 1));
    // The open run is always closed at block end, so index 0 never merges and
    // the registered block mode is valid whenever merge can be true.
    assign merge     = open_q && (data_in == val_q) && (len_q < CNT_WIDTH'(MAX_RUN)) &&
                       (!mode_q || (data_in == '0));

    always_comb begin
        state_d = state_q;
        open_d  = open_q;
        val_d   = val_q;
        len_d   = len_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        ovld_d  = ovld_q && !run_ready_in;
        oval_d  = oval_q;
        ocnt_d  = ocnt_q;
        olast_d = olast_q;
        runs_d  = runs_q;
        done_d  = 1'b0;
        ld      = 1'b0;
        ld_val  = val_q;
        ld_cnt  = len_q;
        ld_last = 1'b0;

        case (state_q)
            ACCUM: begin
                if (accept) begin
                    if (idx_q == '0) mode_d = mode_in;
                    if (!is_last) begin
                        idx_d = idx_q + IDX_W'(1);
                        if (merge) begin
                            len_d = len_q + ONE;
                        end else begin
                            ld     = open_q;
                            open_d = 1'b1;
                            val_d  = data_in;
                            len_d  = ONE;
                        end
                    end else if (merge || !open_q) begin
                        ld      = 1'b1;
                        ld_val  = data_in;
                        ld_cnt  = merge ? len_q + ONE : ONE;
                        ld_last = 1'b1;
                        open_d  = 1'b0;
                        idx_d   = '0;
                    end else begin
                        ld      = 1'b1;
                        open_d  = 1'b1;
                        val_d   = data_in;
                        len_d   = ONE;
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (out_free) begin
                    ld      = 1'b1;
                    ld_last = 1'b1;
                    open_d  = 1'b0;
                    idx_d   = '0;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase

        if (ld) begin
            ovld_d  = 1'b1;
            oval_d  = ld_val;
            ocnt_d  = ld_cnt;
            olast_d = ld_last;
            if (ld_last) begin
                runs_d = cnt_q + ONE;
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d  = cnt_q + ONE;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q <= ACCUM;
            open_q  <= 1'b0;
            val_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            ovld_q  <= 1'b0;
            oval_q  <= '0;
            ocnt_q  <= '0;
            olast_q <= 1'b0;
            runs_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            open_q  <= open_d;
            val_q   <= val_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            ovld_q  <= ovld_d;
            oval_q  <= oval_d;
            ocnt_q  <= ocnt_d;
            olast_q <= olast_d;
            runs_q  <= runs_d;
            done_q  <= done_d;
        end
    end

    assign run_valid_out  = ovld_q;
    assign run_value_out  = oval_q;
    assign run_count_out  = ocnt_q;
    assign run_last_out   = olast_q;
    assign runs_out       = runs_q;
    assign block_done_out = done_q;

endmodule

// File: tb/tb_rle_stream_encoder.sv
// Bench for rle_stream_encoder: directed and random blocks checked against a list-based
// run model; a second instance with MAX_RUN=15 covers saturation.
module tb_rle_stream_encoder;
    typedef struct {
        int v;
        int c;
        int l;
        int cyc;
    } pair_t;

    logic       clk = 1'b0;
    logic       rst_n, valid, mode;
    logic [7:0] din;
    logic       rr = 1'b1;
    int         sel, bp_mode;
    int         cyc = 0;

    logic       va, vb, rdy_a, rdy_b, rl_a, rl_b, rvo_a, rvo_b, done_a, done_b;
    logic [7:0] rv_a, rv_b;
    logic [6:0] rc_a, rc_b, runs_a, runs_b;

    logic       m_rdy, m_last, m_vld, m_done;
    logic [7:0] m_val;
    logic [6:0] m_cnt, m_runs;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0: rr <= 1'b1;
            1: rr <= 1'($urandom_range(0, 1));
            default: rr <= 1'b0;
        endcase
    end

    assign va     = valid && (sel == 0);
    assign vb     = valid && (sel == 1);
    assign m_rdy  = sel ? rdy_b  : rdy_a;
    assign m_val  = sel ? rv_b   : rv_a;
    assign m_cnt  = sel ? rc_b   : rc_a;
    assign m_last = sel ? rl_b   : rl_a;
    assign m_vld  = sel ? rvo_b  : rvo_a;
    assign m_runs = sel ? runs_b : runs_a;
    assign m_done = sel ? done_b : done_a;

    rle_stream_encoder dut_a (
        .clk_in(clk), .rst_n_in(rst_n), .data_in(din), .valid_in(va), .ready_out(rdy_a),
        .mode_in(mode), .run_value_out(rv_a), .run_count_out(rc_a), .run_last_out(rl_a),
        .run_valid_out(rvo_a), .run_ready_in(rr), .runs_out(runs_a), .block_done_out(done_a)
    );

    rle_stream_encoder #(.MAX_RUN(15)) dut_b (
        .clk_in(clk), .rst_n_in(rst_n), .data_in(din), .valid_in(vb), .ready_out(rdy_b),
        .mode_in(mode), .run_value_out(rv_b), .run_count_out(rc_b), .run_last_out(rl_b),
        .run_valid_out(rvo_b), .run_ready_in(rr), .runs_out(runs_b), .block_done_out(done_b)
    );

    // Monitor: outputs sampled on the falling edge, i.e. what the next rising edge will see.
    pair_t      obs_q[$];
    int         dones = 0, unstable = 0;
    logic       p_vld = 1'b0, p_rr = 1'b1;
    logic [7:0] p_val;
    logic [6:0] p_cnt;
    logic       p_last;

    always @(negedge clk) begin
        if (rst_n) begin
            if (p_vld && !p_rr &&
                !(m_vld && m_val == p_val && m_cnt == p_cnt && m_last == p_last))
                unstable <= unstable + 1;
            if (m_vld && rr) obs_q.push_back('{int'(m_val), int'(m_cnt), int'(m_last), cyc});
            if (m_done) dones <= dones + 1;
        end
        p_vld  <= rst_n && m_vld;
        p_rr   <= rr;
        p_val  <= m_val;
        p_cnt  <= m_cnt;
        p_last <= m_last;
    end

    int         checks = 0, errors = 0;
    logic [7:0] blk[64];
    logic       mvec[64];
    pair_t      exp_q[$];
    int         base, dbase, ubase, stalls, last_acc, lows;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: split the block into maximal runs under the run-break rules.
    task automatic build_exp(input int max_run);
        pair_t t;
        exp_q.delete();
        for (int i = 0; i < 64; i++) begin
            bit start;
            start = (i == 0);
            if (!start) begin
                t = exp_q[exp_q.size()-1];
                start = (int'(blk[i]) != t.v) || (t.c == max_run) || (mvec[0] && blk[i] != 0);
            end
            if (start) exp_q.push_back('{int'(blk[i]), 1, 0, 0});
            else begin
                t.c++;
                exp_q[exp_q.size()-1] = t;
            end
        end
        t = exp_q[exp_q.size()-1];
        t.l = 1;
        exp_q[exp_q.size()-1] = t;
    endtask

    task automatic push(input logic [7:0] d, input logic m);
        int t;
        t = 0;
        din = d; mode = m; valid = 1'b1;
        @(negedge clk);
        while (!m_rdy && t < 1000) begin
            stalls++; t++;
            @(negedge clk);
        end
        if (t >= 1000) chk("accept_wait", t, 0);
        last_acc = cyc;
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic send(input int n, input int gap_max);
        for (int i = 0; i < n; i++) begin
            push(blk[i], mvec[i]);
            repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic start_block();
        base = obs_q.size();
        dbase = dones;
        ubase = unstable;
        stalls = 0;
    endtask

    task automatic check_block(input string tag, input int max_run, input int exp_lat);
        int t, n;
        build_exp(max_run);
        t = 0;
        while (!(obs_q.size() > base && obs_q[obs_q.size()-1].l == 1) && t < 2000) begin
            @(negedge clk); t++;
        end
        repeat (4) @(negedge clk);
        chk({tag, "/drain"}, int'(t < 2000), 1);
        n = obs_q.size() - base;
        chk({tag, "/npairs"}, n, exp_q.size());
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            chk({tag, "/val"},  obs_q[base+i].v, exp_q[i].v);
            chk({tag, "/cnt"},  obs_q[base+i].c, exp_q[i].c);
            chk({tag, "/last"}, obs_q[base+i].l, exp_q[i].l);
        end
        chk({tag, "/runs_out"}, int'(m_runs), exp_q.size());
        chk({tag, "/done_pulses"}, dones - dbase, 1);
        chk({tag, "/stable"}, unstable - ubase, 0);
        if (exp_lat > 0 && n > 0) chk({tag, "/latency"}, obs_q[obs_q.size()-1].cyc - last_acc, exp_lat);
        @(posedge clk); #1;
    endtask

    task automatic count_bubble();
        lows = 0;
        repeat (3) begin
            @(negedge clk);
            if (!m_rdy) lows++;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b0; din = '0; mode = 1'b0; sel = 0; bp_mode = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst/ready_a", int'(rdy_a), 0);
        chk("rst/ready_b", int'(rdy_b), 0);
        chk("rst/valid", int'(rvo_a), 0);
        chk("rst/value", int'(rv_a), 0);
        chk("rst/count", int'(rc_a), 0);
        chk("rst/runs", int'(runs_a), 0);
        chk("rst/done", int'(done_a), 0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        chk("rst/ready_after", int'(rdy_a), 1);
        @(posedge clk); #1;

        // 1: generic mode, merging last element
        foreach (blk[i]) begin blk[i] = 8'd0; mvec[i] = 1'b0; end
        blk[0] = 8'd5; blk[4] = 8'd4;
        start_block(); send(64, 0); count_bubble();
        chk("t1/bubble", lows, 0);
        check_block("t1", 64, 1);

        // 2: saturation at 64 and at 15
        foreach (blk[i]) blk[i] = 8'd7;
        start_block(); send(64, 0); check_block("t2a", 64, 1);
        sel = 1;
        start_block(); send(64, 0); check_block("t2b", 15, 0);
        sel = 0;

        // 3: zero-run mode with mode_in toggling mid-block
        foreach (blk[i]) begin blk[i] = 8'd0; mvec[i] = 1'(i % 2); end
        blk[0] = 8'd3; blk[1] = 8'd3; blk[5] = 8'd2; mvec[0] = 1'b1;
        start_block(); send(64, 1); check_block("t3", 64, 0);

        // 4: non-merging last element forces one FLUSH cycle
        foreach (blk[i]) begin blk[i] = 8'd1; mvec[i] = 1'b0; end
        blk[63] = 8'd9;
        start_block(); send(64, 0); count_bubble();
        chk("t4/bubble", lows, 1);
        check_block("t4", 64, 2);

        // 5: alternating values with downstream stalled for 10 cycles
        foreach (blk[i]) blk[i] = 8'(1 + (i % 2));
        bp_mode = 2;
        @(posedge clk); #1;
        start_block();
        fork
            send(64, 0);
            begin repeat (10) @(posedge clk); bp_mode = 0; end
        join
        chk("t5/ready_dropped", int'(stalls > 0), 1);
        check_block("t5", 64, 0);

        // 6: reset mid-block discards the partial block
        foreach (blk[i]) blk[i] = 8'($urandom_range(0, 3));
        send(20, 0);
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("t6/rst_valid", int'(m_vld), 0);
        chk("t6/rst_ready", int'(m_rdy), 0);
        chk("t6/rst_runs", int'(m_runs), 0);
        chk("t6/rst_last", int'(m_last), 0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        chk("t6/ready_after", int'(m_rdy), 1);
        @(posedge clk); #1;
        foreach (blk[i]) blk[i] = 8'd4;
        start_block(); send(64, 0); check_block("t6", 64, 1);

        // random blocks, random backpressure, both instances
        for (int r = 0; r < 12; r++) begin
            logic [7:0] cur;
            sel = int'($urandom_range(0, 1));
            bp_mode = int'($urandom_range(0, 1));
            cur = 8'($urandom_range(0, 3));
            for (int i = 0; i < 64; i++) begin
                if ($urandom_range(0, 9) < 3) cur = 8'($urandom_range(0, 3));
                blk[i] = cur;
                mvec[i] = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            start_block(); send(64, 2); check_block("rnd", sel ? 15 : 64, 0);
        end
        bp_mode = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
